// File: rtl/probe_seq_pkg.sv
// Shared definitions for the probe sequencer.
//   state_t      : sequencer FSM states
//   FM_*         : frequency mode encodings
//   OFS_*        : configuration offsets relative to BASE_ADDR
//   cfg_t        : scalar configuration fields
//   eff_freq_mode: maps an undefined frequency mode onto fixed mode
//   eff_steps    : number of frequency steps a run actually performs
package probe_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_FREQ_SET,
    S_FREQ_WAIT,
    S_REP,
    S_CODE,
    S_GEN_REQ,
    S_GEN_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [7:0] FM_FIXED = 8'd1;
  localparam logic [7:0] FM_STEP  = 8'd2;
  localparam logic [7:0] FM_HOP   = 8'd3;

  localparam logic [15:0] OFS_PROBE_MODE  = 16'd0;
  localparam logic [15:0] OFS_INTERVAL    = 16'd1;
  localparam logic [15:0] OFS_REPS        = 16'd2;
  localparam logic [15:0] OFS_FREQ_MODE   = 16'd3;
  localparam logic [15:0] OFS_START_FREQW = 16'd4;
  localparam logic [15:0] OFS_STEP_FREQW  = 16'd5;
  localparam logic [15:0] OFS_STEP_COUNT  = 16'd6;
  localparam logic [15:0] OFS_CODE_COUNT  = 16'd7;
  localparam logic [15:0] OFS_CODE_LEN    = 16'd8;
  localparam logic [15:0] OFS_CODE_DUR    = 16'd9;
  localparam logic [15:0] OFS_PULSE_LEN   = 16'd10;
  localparam logic [15:0] OFS_CODES       = 16'd16;

  // scalar registers plus one "any code written" flag
  localparam int N_CFG_FLAGS = 12;

  typedef struct packed {
    logic [7:0]  probe_mode;
    logic [31:0] interval;
    logic [15:0] repetitions;
    logic [7:0]  freq_mode;
    logic [15:0] step_count;
    logic [8:0]  code_count;
    logic [15:0] code_len;
    logic [15:0] code_dur;
    logic [15:0] pulse_len;
  } cfg_t;

  function automatic logic [7:0] eff_freq_mode(input logic [7:0] mode);
    return (mode == FM_STEP || mode == FM_HOP) ? mode : FM_FIXED;
  endfunction

  function automatic logic [15:0] eff_steps(input logic [7:0]  mode,
                                            input logic [15:0] count,
                                            input logic [15:0] hop_depth);
    logic [7:0] m;
    m = eff_freq_mode(mode);
    if (m == FM_STEP) return count;
    if (m == FM_HOP)  return (count > hop_depth) ? hop_depth : count;
    return 16'd1;
  endfunction

endpackage

// File: rtl/probe_sequencer_cfg.sv
// Configuration bank: scalar register file, code table, hop table and the
// written-since-reset mask behind CFG_OK. Tables have a registered read
// port so they map onto block RAM; the sequencer presents the address one
// state ahead of use.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_wr/i_addr/i_data  : write strobe, absolute address, data
//   i_busy              : run in progress, writes are dropped
//   i_code_raddr        : code table read address (data next cycle)
//   i_hop_raddr         : hop table read address (data next cycle)
//   o_cfg               : scalar fields
//   o_start_freqw/o_step_freqw : frequency words
//   o_code_rdata/o_hop_rdata   : registered table read data
//   o_cfg_ok            : every scalar and at least one code written
module probe_cfg_bank
  import probe_seq_pkg::*;
#(
  parameter int CODE_W     = 32,
  parameter int CODE_DEPTH = 32,
  parameter int HOP_DEPTH  = 16,
  parameter int FREQ_W     = 32,
  parameter int BASE_ADDR  = 120,
  localparam int CA_W = $clog2(CODE_DEPTH),
  localparam int HA_W = $clog2(HOP_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [15:0]       i_addr,
  input  logic [31:0]       i_data,
  input  logic              i_busy,
  input  logic [CA_W-1:0]   i_code_raddr,
  input  logic [HA_W-1:0]   i_hop_raddr,
  output cfg_t              o_cfg,
  output logic [FREQ_W-1:0] o_start_freqw,
  output logic [FREQ_W-1:0] o_step_freqw,
  output logic [CODE_W-1:0] o_code_rdata,
  output logic [FREQ_W-1:0] o_hop_rdata,
  output logic              o_cfg_ok
);

  localparam logic [15:0] OFS_HOP = 16'(OFS_CODES + CODE_DEPTH);
  localparam logic [15:0] OFS_END = 16'(OFS_CODES + CODE_DEPTH + HOP_DEPTH);

  cfg_t                   r_cfg;
  logic [FREQ_W-1:0]      r_start_freqw;
  logic [FREQ_W-1:0]      r_step_freqw;
  logic [N_CFG_FLAGS-1:0] r_mask;
  logic [CODE_W-1:0]      r_code_mem [CODE_DEPTH];
  logic [FREQ_W-1:0]      r_hop_mem  [HOP_DEPTH];
  logic [CODE_W-1:0]      r_code_rdata;
  logic [FREQ_W-1:0]      r_hop_rdata;

  logic [15:0]     w_ofs;
  logic            w_wr_ok;
  logic            w_code_we;
  logic            w_hop_we;
  logic [CA_W-1:0] w_code_waddr;
  logic [HA_W-1:0] w_hop_waddr;

  assign w_ofs        = i_addr - 16'(BASE_ADDR);
  assign w_wr_ok      = i_wr && !i_busy && (i_addr >= 16'(BASE_ADDR));
  assign w_code_we    = w_wr_ok && (w_ofs >= OFS_CODES) && (w_ofs < OFS_HOP);
  assign w_hop_we     = w_wr_ok && (w_ofs >= OFS_HOP) && (w_ofs < OFS_END);
  assign w_code_waddr = CA_W'(w_ofs - OFS_CODES);
  assign w_hop_waddr  = HA_W'(w_ofs - OFS_HOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg         <= '0;
      r_start_freqw <= '0;
      r_step_freqw  <= '0;
      r_mask        <= '0;
    end else if (w_wr_ok) begin
      case (w_ofs)
        OFS_PROBE_MODE:  begin r_cfg.probe_mode  <= i_data[7:0];  r_mask[0]  <= 1'b1; end
        OFS_INTERVAL:    begin r_cfg.interval    <= i_data;       r_mask[1]  <= 1'b1; end
        OFS_REPS:        begin r_cfg.repetitions <= i_data[15:0]; r_mask[2]  <= 1'b1; end
        OFS_FREQ_MODE:   begin r_cfg.freq_mode   <= i_data[7:0];  r_mask[3]  <= 1'b1; end
        OFS_START_FREQW: begin r_start_freqw <= FREQ_W'(i_data);  r_mask[4]  <= 1'b1; end
        OFS_STEP_FREQW:  begin r_step_freqw  <= FREQ_W'(i_data);  r_mask[5]  <= 1'b1; end
        OFS_STEP_COUNT:  begin r_cfg.step_count  <= i_data[15:0]; r_mask[6]  <= 1'b1; end
        OFS_CODE_COUNT:  begin r_cfg.code_count  <= i_data[8:0];  r_mask[7]  <= 1'b1; end
        OFS_CODE_LEN:    begin r_cfg.code_len    <= i_data[15:0]; r_mask[8]  <= 1'b1; end
        OFS_CODE_DUR:    begin r_cfg.code_dur    <= i_data[15:0]; r_mask[9]  <= 1'b1; end
        OFS_PULSE_LEN:   begin r_cfg.pulse_len   <= i_data[15:0]; r_mask[10] <= 1'b1; end
        default: ;
      endcase
      if (w_code_we) r_mask[11] <= 1'b1;
    end
  end

  // Tables carry no reset so they stay inferable as RAM.
  always_ff @(posedge i_clk) begin
    if (w_code_we) r_code_mem[w_code_waddr] <= CODE_W'(i_data);
    r_code_rdata <= r_code_mem[i_code_raddr];
  end

  always_ff @(posedge i_clk) begin
    if (w_hop_we) r_hop_mem[w_hop_waddr] <= FREQ_W'(i_data);
    r_hop_rdata <= r_hop_mem[i_hop_raddr];
  end

  assign o_cfg         = r_cfg;
  assign o_start_freqw = r_start_freqw;
  assign o_step_freqw  = r_step_freqw;
  assign o_code_rdata  = r_code_rdata;
  assign o_hop_rdata   = r_hop_rdata;
  assign o_cfg_ok      = &r_mask;

endmodule

// File: rtl/probe_sequencer.sv
// Probe sequencer: steps frequencies x repetitions x codes, with an
// UPDATE/UPDATED handshake per frequency and GEN/GEN_DONE per code.
//   CLOCK_10M, RESET_N : clock, async active-low reset
//   CFG_WR/ADDR/DATA   : configuration write port (ignored while BUSY)
//   START, ABORT       : run start (rising edge) and abort
//   INITIED, UPDATED   : DDS driver ready / update acknowledge
//   GEN_DONE           : generator + receiver finished
//   UPDATE, FREQW      : DDS update request and tuning word
//   GEN, CODE          : generate request and current code
//   CODE_LEN, CODE_DURATION, PULSE_LEN, PROBE_MODE : latched at start
//   RF_OUTPUT_EN, BUSY, DONE, CFG_OK : status
//
// state       | meaning
// ------------+------------------------------------------------
// S_IDLE      | waiting for START rising edge
// S_WAIT_INIT | run parameters latched, waiting for INITIED
// S_FREQ_SET  | load FREQW for step_idx and raise UPDATE, or finish
// S_FREQ_WAIT | UPDATE held until UPDATED, then wait UPDATED low
// S_REP       | next repetition, or advance frequency step
// S_CODE      | load CODE for code_idx, or end repetition
// S_GEN_REQ   | raise GEN
// S_GEN_WAIT  | wait GEN_DONE, then load gap timer
// S_GAP       | gap timer down-count to zero
// S_DONE      | one-cycle DONE pulse, back to idle
module probe_sequencer
  import probe_seq_pkg::*;
#(
  parameter int CODE_W     = 32,
  parameter int CODE_DEPTH = 32,
  parameter int HOP_DEPTH  = 16,
  parameter int FREQ_W     = 32,
  parameter int BASE_ADDR  = 120
) (
  input  logic              CLOCK_10M,
  input  logic              RESET_N,
  input  logic              CFG_WR,
  input  logic [15:0]       CFG_ADDR,
  input  logic [31:0]       CFG_DATA,
  input  logic              START,
  input  logic              ABORT,
  input  logic              INITIED,
  input  logic              UPDATED,
  input  logic              GEN_DONE,
  output logic              UPDATE,
  output logic [FREQ_W-1:0] FREQW,
  output logic              GEN,
  output logic [CODE_W-1:0] CODE,
  output logic [15:0]       CODE_LEN,
  output logic [15:0]       CODE_DURATION,
  output logic [15:0]       PULSE_LEN,
  output logic [7:0]        PROBE_MODE,
  output logic              RF_OUTPUT_EN,
  output logic              BUSY,
  output logic              DONE,
  output logic              CFG_OK
);

  localparam int CA_W = $clog2(CODE_DEPTH);
  localparam int HA_W = $clog2(HOP_DEPTH);

  cfg_t              w_cfg;
  logic [FREQ_W-1:0] w_start_freqw;
  logic [FREQ_W-1:0] w_step_freqw;
  logic [CODE_W-1:0] w_code_rdata;
  logic [FREQ_W-1:0] w_hop_rdata;
  logic              w_cfg_ok;

  state_t            r_state, w_state_nxt;
  logic              r_start_q;
  logic              r_latch;
  logic              r_busy,   w_busy_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_update, w_update_nxt;
  logic              r_gen,    w_gen_nxt;
  logic [FREQ_W-1:0] r_freqw,  w_freqw_nxt;
  logic [CODE_W-1:0] r_code,   w_code_nxt;
  logic [15:0]       r_step_idx, w_step_nxt;
  logic [15:0]       r_rep_idx,  w_rep_nxt;
  logic [8:0]        r_code_idx, w_cidx_nxt;
  logic [31:0]       r_gap_cnt,  w_gap_nxt;
  logic [FREQ_W-1:0] r_freq_acc, w_acc_nxt;

  logic [7:0]        r_probe_mode;
  logic [31:0]       r_interval;
  logic [15:0]       r_reps;
  logic [7:0]        r_fmode;
  logic [15:0]       r_steps;
  logic [8:0]        r_ncodes;
  logic [FREQ_W-1:0] r_start_freqw;
  logic [FREQ_W-1:0] r_step_freqw;
  logic [15:0]       r_code_len;
  logic [15:0]       r_code_dur;
  logic [15:0]       r_pulse_len;

  logic w_start_edge;
  assign w_start_edge = START && !r_start_q;

  probe_cfg_bank #(
    .CODE_W    (CODE_W),
    .CODE_DEPTH(CODE_DEPTH),
    .HOP_DEPTH (HOP_DEPTH),
    .FREQ_W    (FREQ_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_cfg (
    .i_clk        (CLOCK_10M),
    .i_rst_n      (RESET_N),
    .i_wr         (CFG_WR),
    .i_addr       (CFG_ADDR),
    .i_data       (CFG_DATA),
    .i_busy       (r_busy),
    .i_code_raddr (CA_W'(w_cidx_nxt)),
    .i_hop_raddr  (HA_W'(w_step_nxt)),
    .o_cfg        (w_cfg),
    .o_start_freqw(w_start_freqw),
    .o_step_freqw (w_step_freqw),
    .o_code_rdata (w_code_rdata),
    .o_hop_rdata  (w_hop_rdata),
    .o_cfg_ok     (w_cfg_ok)
  );

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= S_IDLE;
      r_start_q  <= 1'b0;
      r_latch    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_update   <= 1'b0;
      r_gen      <= 1'b0;
      r_freqw    <= '0;
      r_code     <= '0;
      r_step_idx <= '0;
      r_rep_idx  <= '0;
      r_code_idx <= '0;
      r_gap_cnt  <= '0;
      r_freq_acc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_start_q  <= START;
      r_latch    <= (r_state == S_IDLE) && w_start_edge;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_update   <= w_update_nxt;
      r_gen      <= w_gen_nxt;
      r_freqw    <= w_freqw_nxt;
      r_code     <= w_code_nxt;
      r_step_idx <= w_step_nxt;
      r_rep_idx  <= w_rep_nxt;
      r_code_idx <= w_cidx_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_freq_acc <= w_acc_nxt;
    end
  end

  // Parameters are captured the cycle after the start edge: BUSY already
  // blocks writes by then, and a write coincident with the edge is included.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_probe_mode  <= '0;
      r_interval    <= '0;
      r_reps        <= '0;
      r_fmode       <= '0;
      r_steps       <= '0;
      r_ncodes      <= '0;
      r_start_freqw <= '0;
      r_step_freqw  <= '0;
      r_code_len    <= '0;
      r_code_dur    <= '0;
      r_pulse_len   <= '0;
    end else if (r_latch) begin
      r_probe_mode  <= w_cfg.probe_mode;
      r_interval    <= w_cfg.interval;
      r_reps        <= w_cfg.repetitions;
      r_fmode       <= eff_freq_mode(w_cfg.freq_mode);
      r_steps       <= eff_steps(w_cfg.freq_mode, w_cfg.step_count, 16'(HOP_DEPTH));
      r_ncodes      <= (w_cfg.code_count > 9'(CODE_DEPTH)) ? 9'(CODE_DEPTH) : w_cfg.code_count;
      r_start_freqw <= w_start_freqw;
      r_step_freqw  <= w_step_freqw;
      r_code_len    <= w_cfg.code_len;
      r_code_dur    <= w_cfg.code_dur;
      r_pulse_len   <= w_cfg.pulse_len;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_update_nxt = r_update;
    w_gen_nxt    = r_gen;
    w_freqw_nxt  = r_freqw;
    w_code_nxt   = r_code;
    w_step_nxt   = r_step_idx;
    w_rep_nxt    = r_rep_idx;
    w_cidx_nxt   = r_code_idx;
    w_gap_nxt    = r_gap_cnt;
    w_acc_nxt    = r_freq_acc;

    if (ABORT && r_state != S_IDLE && r_state != S_DONE) begin
      w_state_nxt  = S_DONE;
      w_update_nxt = 1'b0;
      w_gen_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            w_state_nxt = S_WAIT_INIT;
            w_busy_nxt  = 1'b1;
            w_step_nxt  = '0;
            w_rep_nxt   = '0;
            w_cidx_nxt  = '0;
          end
        end
        S_WAIT_INIT: begin
          if (INITIED) begin
            w_state_nxt = S_FREQ_SET;
            w_acc_nxt   = w_start_freqw;
          end
        end
        S_FREQ_SET: begin
          if (r_step_idx < r_steps) begin
            if (r_fmode == FM_HOP)       w_freqw_nxt = w_hop_rdata;
            else if (r_fmode == FM_STEP) w_freqw_nxt = r_freq_acc;
            else                         w_freqw_nxt = r_start_freqw;
            w_update_nxt = 1'b1;
            w_state_nxt  = S_FREQ_WAIT;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
        S_FREQ_WAIT: begin
          if (r_update) begin
            if (UPDATED) w_update_nxt = 1'b0;
          end else if (!UPDATED) begin
            w_state_nxt = S_REP;
          end
        end
        S_REP: begin
          if (r_rep_idx < r_reps) begin
            w_cidx_nxt  = '0;
            w_state_nxt = S_CODE;
          end else begin
            w_step_nxt  = r_step_idx + 16'd1;
            w_rep_nxt   = '0;
            w_acc_nxt   = r_freq_acc + r_step_freqw;
            w_state_nxt = S_FREQ_SET;
          end
        end
        S_CODE: begin
          if (r_code_idx < r_ncodes) begin
            w_code_nxt  = w_code_rdata;
            w_state_nxt = S_GEN_REQ;
          end else begin
            w_rep_nxt   = r_rep_idx + 16'd1;
            w_state_nxt = S_REP;
          end
        end
        S_GEN_REQ: begin
          w_gen_nxt   = 1'b1;
          w_state_nxt = S_GEN_WAIT;
        end
        S_GEN_WAIT: begin
          if (GEN_DONE) begin
            w_gen_nxt   = 1'b0;
            w_cidx_nxt  = r_code_idx + 9'd1;
            w_gap_nxt   = r_interval;
            w_state_nxt = S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 32'd0) w_state_nxt = S_CODE;
          else                    w_gap_nxt   = r_gap_cnt - 32'd1;
        end
        S_DONE: begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // r_latch masks the first busy cycle, when PROBE_MODE still holds the
  // previous run's value.
  assign RF_OUTPUT_EN  = r_busy && !r_latch &&
                         (r_probe_mode == 8'd1 || r_probe_mode == 8'd2 || r_probe_mode == 8'd4);
  assign UPDATE        = r_update;
  assign FREQW         = r_freqw;
  assign GEN           = r_gen;
  assign CODE          = r_code;
  assign CODE_LEN      = r_code_len;
  assign CODE_DURATION = r_code_dur;
  assign PULSE_LEN     = r_pulse_len;
  assign PROBE_MODE    = r_probe_mode;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign CFG_OK        = w_cfg_ok;

endmodule

// File: tb/tb_probe_sequencer.sv
module tb_probe_sequencer;

  localparam int BASE    = 120;
  localparam int OFS_HOP = 16 + 32;

  logic        CLOCK_10M = 1'b0;
  logic        RESET_N   = 1'b0;
  logic        CFG_WR    = 1'b0;
  logic [15:0] CFG_ADDR  = '0;
  logic [31:0] CFG_DATA  = '0;
  logic        START     = 1'b0;
  logic        ABORT     = 1'b0;
  logic        INITIED   = 1'b0;
  logic        UPDATED   = 1'b0;
  logic        GEN_DONE  = 1'b0;
  logic        UPDATE, GEN, RF_OUTPUT_EN, BUSY, DONE, CFG_OK;
  logic [31:0] FREQW, CODE;
  logic [15:0] CODE_LEN, CODE_DURATION, PULSE_LEN;
  logic [7:0]  PROBE_MODE;

  int n_cmp = 0;
  int n_err = 0;
  int n_upd, n_gen, n_done;
  logic [63:0] q_freq[$];
  logic [63:0] q_code[$];
  logic [31:0] codes [3] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};

  probe_sequencer dut (
    .CLOCK_10M(CLOCK_10M), .RESET_N(RESET_N), .CFG_WR(CFG_WR), .CFG_ADDR(CFG_ADDR),
    .CFG_DATA(CFG_DATA), .START(START), .ABORT(ABORT), .INITIED(INITIED),
    .UPDATED(UPDATED), .GEN_DONE(GEN_DONE), .UPDATE(UPDATE), .FREQW(FREQW),
    .GEN(GEN), .CODE(CODE), .CODE_LEN(CODE_LEN), .CODE_DURATION(CODE_DURATION),
    .PULSE_LEN(PULSE_LEN), .PROBE_MODE(PROBE_MODE), .RF_OUTPUT_EN(RF_OUTPUT_EN),
    .BUSY(BUSY), .DONE(DONE), .CFG_OK(CFG_OK)
  );

  always #50 CLOCK_10M = ~CLOCK_10M;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input int ofs, input logic [31:0] data);
    @(negedge CLOCK_10M);
    CFG_WR = 1'b1; CFG_ADDR = 16'(BASE + ofs); CFG_DATA = data;
    @(negedge CLOCK_10M);
    CFG_WR = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_10M);
  endtask

  // Plays the DDS driver and generator; checks scoreboard entries as the
  // DUT presents them. Stops at the first DONE or when the budget runs out.
  task automatic run_seq(input int budget, input int abort_gen, input int gap_exp,
                         input int cpr, input logic rf_exp);
    int cyc = 0;
    int since = -1;
    bit upd_ack = 0;
    bit gen_ack = 0;
    bit fin = 0;
    n_upd = 0; n_gen = 0; n_done = 0;
    while (!fin && cyc < budget) begin
      @(negedge CLOCK_10M);
      cyc++;
      if (since >= 0) since++;
      if (upd_ack) begin
        chk("update_drop", UPDATE, 0);
        UPDATED = 1'b0; upd_ack = 0;
      end else if (UPDATE) begin
        n_upd++;
        if (n_upd == 1) chk("busy_in_run", BUSY, 1);
        if (q_freq.size() > 0) chk("freqw", FREQW, q_freq.pop_front());
        UPDATED = 1'b1; upd_ack = 1;
      end
      if (gen_ack) begin
        chk("gen_drop", GEN, 0);
        GEN_DONE = 1'b0; ABORT = 1'b0; gen_ack = 0;
      end else if (GEN) begin
        n_gen++;
        if (q_code.size() > 0) chk("code", CODE, q_code.pop_front());
        chk("rf_en", RF_OUTPUT_EN, rf_exp);
        if (gap_exp >= 0 && since >= 0 && ((n_gen - 1) % cpr) != 0)
          chk("gap", since, gap_exp);
        if (n_gen == abort_gen) ABORT = 1'b1;
        else GEN_DONE = 1'b1;
        gen_ack = 1; since = 0;
      end
      if (DONE) begin
        n_done++;
        chk("busy_at_done", BUSY, 0);
        fin = 1;
      end
    end
    chk("run_finished", fin, 1);
    UPDATED = 1'b0; GEN_DONE = 1'b0; ABORT = 1'b0;
  endtask

  // START still high after DONE must not start another run.
  task automatic hold_check();
    int acc = 0;
    repeat (6) begin
      @(negedge CLOCK_10M);
      if (BUSY || DONE) acc++;
    end
    chk("no_retrigger", acc, 0);
    START = 1'b0;
    idle(2);
  endtask

  initial begin
    int seen;
    int dcount;
    idle(2);
    chk("rst_busy", BUSY, 0);
    chk("rst_update", UPDATE, 0);
    chk("rst_gen", GEN, 0);
    chk("rst_freqw", FREQW, 0);
    chk("rst_cfg_ok", CFG_OK, 0);
    RESET_N = 1'b1;
    INITIED = 1'b1;
    idle(2);

    // Fixed frequency, two repetitions of three codes, interval 5.
    cfg_wr(0, 32'h2);
    cfg_wr(1, 32'd5);
    cfg_wr(2, 32'd2);
    cfg_wr(3, 32'd1);
    cfg_wr(4, 32'h1000);
    cfg_wr(5, 32'h55);
    cfg_wr(6, 32'd7);
    cfg_wr(7, 32'd3);
    cfg_wr(8, 32'h11);
    cfg_wr(9, 32'h22);
    cfg_wr(10, 32'h33);
    idle(1);
    chk("cfg_ok_no_code", CFG_OK, 0);
    for (int i = 0; i < 3; i++) cfg_wr(16 + i, codes[i]);
    idle(1);
    chk("cfg_ok_full", CFG_OK, 1);
    q_freq.push_back(64'h1000);
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) q_code.push_back(64'(codes[i]));
    START = 1'b1;
    run_seq(600, -1, 9, 3, 1'b1);
    chk("m1_updates", n_upd, 1);
    chk("m1_gens", n_gen, 6);
    chk("m1_code_q", q_code.size(), 0);
    chk("code_len", CODE_LEN, 16'h11);
    chk("code_dur", CODE_DURATION, 16'h22);
    chk("pulse_len", PULSE_LEN, 16'h33);
    chk("probe_mode", PROBE_MODE, 8'h2);
    hold_check();

    // Linear step with wrap-around, one code per repetition.
    cfg_wr(0, 32'h0);
    cfg_wr(1, 32'd0);
    cfg_wr(2, 32'd1);
    cfg_wr(3, 32'd2);
    cfg_wr(4, 32'hFFFF_FFF0);
    cfg_wr(5, 32'h10);
    cfg_wr(6, 32'd3);
    cfg_wr(7, 32'd1);
    q_freq.push_back(64'hFFFF_FFF0);
    q_freq.push_back(64'h0);
    q_freq.push_back(64'h10);
    repeat (3) q_code.push_back(64'(codes[0]));
    START = 1'b1;
    run_seq(600, -1, -1, 1, 1'b0);
    chk("m2_updates", n_upd, 3);
    chk("m2_gens", n_gen, 3);
    chk("m2_freq_q", q_freq.size(), 0);
    hold_check();

    // Hop table, step_count 20 written in the same cycle as the start edge.
    cfg_wr(3, 32'd3);
    cfg_wr(7, 32'd0);
    for (int i = 0; i < 16; i++) cfg_wr(OFS_HOP + i, 32'h3000_0000 + 32'(i) * 32'h111);
    for (int i = 0; i < 16; i++) q_freq.push_back(64'(32'h3000_0000 + 32'(i) * 32'h111));
    @(negedge CLOCK_10M);
    START = 1'b1; CFG_WR = 1'b1; CFG_ADDR = 16'(BASE + 6); CFG_DATA = 32'd20;
    @(negedge CLOCK_10M);
    CFG_WR = 1'b0;
    run_seq(1200, -1, -1, 1, 1'b0);
    chk("m3_updates", n_upd, 16);
    chk("m3_gens", n_gen, 0);
    chk("m3_freq_q", q_freq.size(), 0);
    hold_check();

    // Undefined freq_mode acts as fixed; zero codes with four repetitions.
    cfg_wr(3, 32'd7);
    cfg_wr(4, 32'h2222);
    cfg_wr(2, 32'd4);
    q_freq.push_back(64'h2222);
    START = 1'b1;
    run_seq(300, -1, -1, 1, 1'b0);
    chk("m0_updates", n_upd, 1);
    chk("m0_gens", n_gen, 0);
    chk("m0_freq_q", q_freq.size(), 0);
    hold_check();

    // Abort during the second GEN_WAIT; writes while BUSY must be dropped.
    cfg_wr(0, 32'h4);
    cfg_wr(1, 32'd5);
    cfg_wr(2, 32'd2);
    cfg_wr(3, 32'd1);
    cfg_wr(4, 32'h1000);
    cfg_wr(7, 32'd3);
    INITIED = 1'b0;
    @(negedge CLOCK_10M);
    START = 1'b1;
    idle(3);
    chk("busy_wait_init", BUSY, 1);
    chk("no_update_uninit", UPDATE, 0);
    cfg_wr(1, 32'd99);
    cfg_wr(7, 32'd1);
    INITIED = 1'b1;
    q_freq.push_back(64'h1000);
    q_code.push_back(64'(codes[0]));
    q_code.push_back(64'(codes[1]));
    run_seq(600, 2, 9, 3, 1'b1);
    chk("ab_gens", n_gen, 2);
    chk("ab_done", n_done, 1);
    hold_check();

    // Same configuration again: the busy-time writes must not have landed.
    q_freq.push_back(64'h1000);
    for (int r = 0; r < 2; r++) for (int i = 0; i < 3; i++) q_code.push_back(64'(codes[i]));
    START = 1'b1;
    run_seq(600, -1, 9, 3, 1'b1);
    chk("rerun_gens", n_gen, 6);
    chk("rerun_code_q", q_code.size(), 0);
    hold_check();

    // Reset while the DDS update is pending.
    seen = 0;
    START = 1'b1;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge CLOCK_10M);
      if (UPDATE) seen = 1;
    end
    chk("reach_freq_wait", seen, 1);
    RESET_N = 1'b0;
    START = 1'b0;
    #1;
    chk("rst_mid_update", UPDATE, 0);
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_freqw", FREQW, 0);
    @(negedge CLOCK_10M);
    RESET_N = 1'b1;
    dcount = 0;
    repeat (10) begin
      @(negedge CLOCK_10M);
      if (DONE) dcount++;
    end
    chk("rst_no_done", dcount, 0);
    chk("rst_cfg_ok_clr", CFG_OK, 0);
    chk("rst_busy_after", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
